// File: rtl/render_pkg.sv
// Shared rendering types and constants for the polygon pipeline.
package render_pkg;

  localparam int COORD_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } loader_state_t;

  localparam logic [3:0] COLOR_BLACK = 4'd0;
  localparam logic [3:0] COLOR_WHITE = 4'd1;
  localparam logic [3:0] COLOR_RED   = 4'd2;
  localparam logic [3:0] COLOR_GREEN = 4'd3;
  localparam logic [3:0] COLOR_BLUE  = 4'd4;

endpackage

// File: rtl/vertex_transform.sv
// World-to-screen mapping: camera-relative offset, integer zoom, then
// recentre on the screen. Plain 32-bit two's-complement arithmetic that wraps.
module vertex_transform
  import render_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 1280,
  parameter int PIXEL_HEIGHT = 720,
  parameter int PIXEL_SCALE  = 1
) (
  input  logic signed [COORD_W-1:0] i_vtx_x,
  input  logic signed [COORD_W-1:0] i_vtx_y,
  input  logic signed [COORD_W-1:0] i_cam_x,
  input  logic signed [COORD_W-1:0] i_cam_y,
  output logic signed [COORD_W-1:0] o_sx,
  output logic signed [COORD_W-1:0] o_sy
);

  localparam logic signed [COORD_W-1:0] SCALE  = COORD_W'(PIXEL_SCALE);
  localparam logic signed [COORD_W-1:0] HALF_W = COORD_W'(PIXEL_WIDTH / 2);
  localparam logic signed [COORD_W-1:0] HALF_H = COORD_W'(PIXEL_HEIGHT / 2);

  logic signed [COORD_W-1:0] w_dx;
  logic signed [COORD_W-1:0] w_dy;

  assign w_dx = i_vtx_x - i_cam_x;
  assign w_dy = i_vtx_y - i_cam_y;
  assign o_sx = w_dx * SCALE + HALF_W;
  assign o_sy = w_dy * SCALE + HALF_H;

endmodule

// File: rtl/polygon_vertex_loader.sv
// Collects a polygon's vertices into a shadow buffer and publishes the whole
// polygon to its output arrays only at a frame boundary.
module polygon_vertex_loader
  import render_pkg::*;
#(
  parameter  int PIXEL_WIDTH      = 1280,
  parameter  int PIXEL_HEIGHT     = 720,
  parameter  int PIXEL_SCALE      = 1,
  parameter  int MAX_NUM_VERTICES = 4,
  localparam int CNT_W            = $clog2(MAX_NUM_VERTICES + 1),
  localparam int IDX_W            = $clog2(MAX_NUM_VERTICES)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      frame_start_in,
  input  logic signed [COORD_W-1:0] camera_x_in,
  input  logic signed [COORD_W-1:0] camera_y_in,
  input  logic                      vtx_valid_in,
  output logic                      vtx_ready_out,
  input  logic signed [COORD_W-1:0] vtx_x_in,
  input  logic signed [COORD_W-1:0] vtx_y_in,
  input  logic                      vtx_last_in,
  output logic signed [COORD_W-1:0] xs_out [MAX_NUM_VERTICES],
  output logic signed [COORD_W-1:0] ys_out [MAX_NUM_VERTICES],
  output logic        [CNT_W-1:0]   num_points_out,
  output logic                      poly_start_out,
  output logic                      poly_valid_out,
  output logic                      error_out
);

  loader_state_t             r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [COORD_W-1:0] r_shadow_x [MAX_NUM_VERTICES];
  logic signed [COORD_W-1:0] r_shadow_y [MAX_NUM_VERTICES];

  logic signed [COORD_W-1:0] w_sx;
  logic signed [COORD_W-1:0] w_sy;
  logic                      w_accept;
  logic                      w_full;
  logic [CNT_W-1:0]          w_total;

  vertex_transform #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .PIXEL_HEIGHT(PIXEL_HEIGHT),
    .PIXEL_SCALE (PIXEL_SCALE)
  ) u_xform (
    .i_vtx_x(vtx_x_in),
    .i_vtx_y(vtx_y_in),
    .i_cam_x(camera_x_in),
    .i_cam_y(camera_y_in),
    .o_sx   (w_sx),
    .o_sy   (w_sy)
  );

  // Ready is only ever high in LOAD, so it doubles as the state qualifier.
  assign w_accept = vtx_valid_in & vtx_ready_out;
  assign w_full   = (r_cnt == CNT_W'(MAX_NUM_VERTICES));
  assign w_total  = w_full ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk_in) begin
    if (w_accept && !w_full) begin
      r_shadow_x[r_cnt[IDX_W-1:0]] <= w_sx;
      r_shadow_y[r_cnt[IDX_W-1:0]] <= w_sy;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= LOAD;
      r_cnt          <= '0;
      vtx_ready_out  <= 1'b0;
      num_points_out <= '0;
      poly_start_out <= 1'b0;
      poly_valid_out <= 1'b0;
      error_out      <= 1'b0;
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        xs_out[i] <= '0;
        ys_out[i] <= '0;
      end
    end else begin
      poly_start_out <= 1'b0;
      error_out      <= 1'b0;
      case (r_state)
        LOAD: begin
          vtx_ready_out <= 1'b1;
          if (w_accept) begin
            if (w_full) error_out <= 1'b1;
            else        r_cnt     <= r_cnt + 1'b1;
            if (vtx_last_in) begin
              if (w_total >= CNT_W'(3)) begin
                r_state       <= DONE;
                vtx_ready_out <= 1'b0;
              end else begin
                r_cnt     <= '0;
                error_out <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          vtx_ready_out <= 1'b0;
          if (frame_start_in) begin
            // Entries beyond the new count keep whatever was published before.
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
              if (CNT_W'(i) < r_cnt) begin
                xs_out[i] <= r_shadow_x[i];
                ys_out[i] <= r_shadow_y[i];
              end
            end
            num_points_out <= r_cnt;
            poly_valid_out <= 1'b1;
            poly_start_out <= 1'b1;
            r_cnt          <= '0;
            r_state        <= LOAD;
            vtx_ready_out  <= 1'b1;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Randomised and directed bench for polygon_vertex_loader against a
// polygon-level reference model (scale 1 and scale 2 instances).
module tb_polygon_vertex_loader;

  localparam int MAXV = 4;
  localparam int CW   = $clog2(MAXV + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, fs, vvalid, vlast;
  logic signed [31:0] vx, vy, cx, cy;

  logic               rdy1, st1, pv1, err1;
  logic               rdy2, st2, pv2, err2;
  logic [CW-1:0]      num1, num2;
  logic signed [31:0] xs1 [MAXV];
  logic signed [31:0] ys1 [MAXV];
  logic signed [31:0] xs2 [MAXV];
  logic signed [31:0] ys2 [MAXV];

  polygon_vertex_loader #(.PIXEL_SCALE(1), .MAX_NUM_VERTICES(MAXV)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs),
    .camera_x_in(cx), .camera_y_in(cy),
    .vtx_valid_in(vvalid), .vtx_ready_out(rdy1),
    .vtx_x_in(vx), .vtx_y_in(vy), .vtx_last_in(vlast),
    .xs_out(xs1), .ys_out(ys1), .num_points_out(num1),
    .poly_start_out(st1), .poly_valid_out(pv1), .error_out(err1)
  );

  polygon_vertex_loader #(.PIXEL_SCALE(2), .MAX_NUM_VERTICES(MAXV)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs),
    .camera_x_in(cx), .camera_y_in(cy),
    .vtx_valid_in(vvalid), .vtx_ready_out(rdy2),
    .vtx_x_in(vx), .vtx_y_in(vy), .vtx_last_in(vlast),
    .xs_out(xs2), .ys_out(ys2), .num_points_out(num2),
    .poly_start_out(st2), .poly_valid_out(pv2), .error_out(err2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: vertices of the polygon being collected, a flag for a
  // completed polygon awaiting a frame boundary, and the published arrays.
  logic signed [31:0] q_x1[$], q_y1[$], q_x2[$], q_y2[$];
  logic signed [31:0] p_x1 [MAXV], p_y1 [MAXV], p_x2 [MAXV], p_y2 [MAXV];
  bit m_pending, m_ready, m_start, m_pv, m_err;
  int m_num;

  function automatic logic signed [31:0] xf(input logic signed [31:0] v, c,
                                            input int scale, input int half);
    return (v - c) * scale + half;
  endfunction

  task automatic clear_poly();
    q_x1.delete(); q_y1.delete(); q_x2.delete(); q_y2.delete();
  endtask

  task automatic step();
    bit acc;
    logic signed [31:0] sx1, sy1, sx2, sy2;
    acc = vvalid && m_ready;
    sx1 = xf(vx, cx, 1, 640); sy1 = xf(vy, cy, 1, 360);
    sx2 = xf(vx, cx, 2, 640); sy2 = xf(vy, cy, 2, 360);
    @(posedge clk);
    #1;
    if (rst) begin
      clear_poly();
      m_pending = 0; m_ready = 0; m_start = 0; m_pv = 0; m_err = 0; m_num = 0;
      for (int i = 0; i < MAXV; i++) begin
        p_x1[i] = 0; p_y1[i] = 0; p_x2[i] = 0; p_y2[i] = 0;
      end
    end else begin
      m_err = 0;
      m_start = 0;
      if (m_pending && fs) begin
        for (int i = 0; i < q_x1.size(); i++) begin
          p_x1[i] = q_x1[i]; p_y1[i] = q_y1[i]; p_x2[i] = q_x2[i]; p_y2[i] = q_y2[i];
        end
        m_num = q_x1.size();
        m_pv = 1;
        m_start = 1;
        m_pending = 0;
        clear_poly();
      end else if (acc) begin
        if (q_x1.size() == MAXV) m_err = 1;
        else begin
          q_x1.push_back(sx1); q_y1.push_back(sy1);
          q_x2.push_back(sx2); q_y2.push_back(sy2);
        end
        if (vlast) begin
          if (q_x1.size() >= 3) m_pending = 1;
          else begin
            m_err = 1;
            clear_poly();
          end
        end
      end
      m_ready = !m_pending;
    end
    check("ready1", rdy1, m_ready);
    check("ready2", rdy2, m_ready);
    check("error1", err1, m_err);
    check("error2", err2, m_err);
    check("start1", st1, m_start);
    check("start2", st2, m_start);
    check("valid1", pv1, m_pv);
    check("valid2", pv2, m_pv);
    check("num1", num1, m_num);
    check("num2", num2, m_num);
    for (int i = 0; i < MAXV; i++) begin
      check($sformatf("xs1[%0d]", i), xs1[i], p_x1[i]);
      check($sformatf("ys1[%0d]", i), ys1[i], p_y1[i]);
      check($sformatf("xs2[%0d]", i), xs2[i], p_x2[i]);
      check($sformatf("ys2[%0d]", i), ys2[i], p_y2[i]);
    end
  endtask

  task automatic send(input int x, input int y, input bit last);
    vvalid = 1; vx = x; vy = y; vlast = last;
    step();
    vvalid = 0; vlast = 0;
  endtask

  task automatic frame();
    fs = 1;
    step();
    fs = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; fs = 0; vvalid = 0; vlast = 0; vx = 0; vy = 0; cx = 640; cy = 360;
    m_pending = 0; m_ready = 0; m_start = 0; m_pv = 0; m_err = 0; m_num = 0;
    idle(3);
    rst = 0;
    idle(1);

    // Square at scale 1 lands on its own world coordinates.
    send(100, 100, 0); send(200, 100, 0); send(200, 200, 0); send(100, 200, 1);
    idle(1);
    frame();
    check("sq_x0", xs1[0], 100); check("sq_x1", xs1[1], 200);
    check("sq_x2", xs1[2], 200); check("sq_x3", xs1[3], 100);
    check("sq_y0", ys1[0], 100); check("sq_y3", ys1[3], 200);
    check("sq_num", num1, 4);
    check("sq_start", st1, 1);
    check("scale2_x0", xs2[0], -440);
    check("scale2_y0", ys2[0], -160);
    idle(2);

    // Overflow: fifth vertex dropped with an error pulse.
    send(1, 2, 0); send(3, 4, 0); send(5, 6, 0); send(7, 8, 0); send(9, 10, 1);
    frame();
    idle(1);

    // Undersize polygon: error, no publish on the following frame.
    send(50, 60, 0); send(70, 80, 1);
    frame();
    check("undersize_nostart", st1, 0);
    idle(1);

    // Last vertex coincident with frame_start: publish waits a frame.
    send(11, 12, 0); send(13, 14, 0);
    fs = 1; send(15, 16, 1); fs = 0;
    idle(2);
    frame();
    idle(1);

    // Reset mid-load discards the partial polygon.
    send(900, 900, 0); send(901, 901, 0);
    rst = 1; idle(2); rst = 0; idle(1);
    send(300, 310, 0); send(320, 330, 0); send(340, 350, 1);
    frame();
    check("rst_tri_num", num1, 3);
    idle(1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      fs     = ($urandom_range(0, 7) == 0);
      vvalid = $urandom_range(0, 1);
      vlast  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        vx = $urandom; vy = $urandom; cx = $urandom; cy = $urandom;
      end else begin
        vx = $urandom_range(0, 4000) - 2000; vy = $urandom_range(0, 4000) - 2000;
        cx = $urandom_range(0, 2000) - 1000; cy = $urandom_range(0, 2000) - 1000;
      end
      step();
    end
    rst = 0; fs = 0; vvalid = 0; vlast = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
